// File: rtl/booth_mult32.sv
// Sequential radix-2 Booth signed multiplier; one add/subtract per clock, WIDTH cycles from start to result.
// Returns the low WIDTH product bits plus an overflow flag; a new start in any state aborts and relatches.
module booth_mult32 #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH:0]   r_m;
  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic             r_q1;
  logic [CW-1:0]    r_cnt;

  logic             w_last;
  logic             w_do_add;
  logic             w_sub;
  logic [WIDTH:0]   w_addend;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_acc;
  logic [WIDTH:0]   w_a_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH:0]   w_top;
  logic             w_ovf;

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // Booth recode {Q[0], q_1}: 01 adds M, 10 subtracts M as A + ~M + 1.
  assign w_do_add = r_q[0] ^ r_q1;
  assign w_sub    = r_q[0] & ~r_q1;
  assign w_addend = w_sub ? ~r_m : r_m;
  // WIDTH+1-bit add: the carry out of the sign-extension bit is dropped, keeping M = -2^(WIDTH-1) exact.
  assign w_sum    = r_a + w_addend + (WIDTH + 1)'(w_sub);
  assign w_acc    = w_do_add ? w_sum : r_a;

  assign w_a_nxt  = {w_acc[WIDTH], w_acc[WIDTH:1]};
  assign w_q_nxt  = {w_acc[0], r_q[WIDTH-1:1]};

  // Product fits in WIDTH signed bits only if the upper half and the result sign bit agree.
  assign w_top    = {w_a_nxt[WIDTH-1:0], w_q_nxt[WIDTH-1]};
  assign w_ovf    = ~((&w_top) | ~(|w_top));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (ctrl_MULT) begin
      w_state_nxt = RUN;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = IDLE;
        RUN:     if (w_last) w_state_nxt = DONE;
        DONE:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_m            <= '0;
      r_a            <= '0;
      r_q            <= '0;
      r_q1           <= 1'b0;
      r_cnt          <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (ctrl_MULT) begin
      r_m   <= {data_operandA[WIDTH-1], data_operandA};
      r_a   <= '0;
      r_q   <= data_operandB;
      r_q1  <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_a   <= w_a_nxt;
      r_q   <= w_q_nxt;
      r_q1  <= r_q[0];
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        data_result    <= w_q_nxt;
        data_exception <= w_ovf;
      end
    end
  end

  assign data_resultRDY = (r_state == DONE);
  assign busy           = (r_state == RUN);

endmodule
